// File: rtl/port_rx_ctl.sv
// Receive-side controller for a handshaked bidirectional port: synchronizes the
// port "R full" flag, strobes the B-side bus into a small FWFT FIFO, then clears the flag.
module port_rx_ctl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             cp,
    input  logic             clr_,
    input  logic             fr,
    input  logic [WIDTH-1:0] d,
    input  logic             rd,
    output logic             oeb_,
    output logic             clrr,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             uflow
);

    localparam int unsigned CW       = AW + 1;
    localparam int unsigned CLRR_BIT = 0;
    localparam int unsigned OEB_BIT  = 1;

    // Encoding carries oeb_ (bit 1) and clrr (bit 0) directly so both are glitch-free flop outputs.
    typedef enum logic [2:0] {
        IDLE    = 3'b010,
        ENABLE  = 3'b000,
        CAPTURE = 3'b100,
        CLEAR   = 3'b011,
        WAIT    = 3'b110
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             fr_m;
    logic             fr_s;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_c;
    logic             pop_c;

    // Two-flop synchronizer for the asynchronous port flag.
    always_ff @(posedge cp) begin
        if (!clr_) begin
            fr_m <= 1'b0;
            fr_s <= 1'b0;
        end else begin
            fr_m <= fr;
            fr_s <= fr_m;
        end
    end

    always_ff @(posedge cp) begin
        if (!clr_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stay in WAIT until the flag drops so one port word is never captured twice.
    always_comb begin
        state_nxt = state;
        push_c    = 1'b0;
        unique case (state)
            IDLE:    if (fr_s && !full) state_nxt = ENABLE;
            ENABLE:  state_nxt = CAPTURE;
            CAPTURE: begin
                state_nxt = CLEAR;
                push_c    = 1'b1;
            end
            CLEAR:   state_nxt = WAIT;
            WAIT:    if (!fr_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign oeb_  = state[OEB_BIT];
    assign clrr  = state[CLRR_BIT];
    assign pop_c = rd && !empty;

    // Pointer, occupancy and underflow bookkeeping.
    always_ff @(posedge cp) begin
        if (!clr_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            uflow  <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (rd && empty) uflow <= 1'b1;
        end
    end

    // Storage is not reset; a reset during CAPTURE suppresses the write.
    always_ff @(posedge cp) begin
        if (clr_ && push_c) begin
            mem[wr_ptr] <= d;
        end
    end

    assign empty = (count == CW'(0));
    assign full  = (count == CW'(DEPTH));
    assign q     = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_port_rx_ctl.sv
// Directed bench for port_rx_ctl: a port model feeds words, a scoreboard queue
// holds expected pops and a negedge monitor checks q on every accepted pop.
module tb_port_rx_ctl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic             cp = 1'b0;
    logic             clr_;
    logic             fr;
    logic [WIDTH-1:0] d;
    logic             rd;
    logic             oeb_;
    logic             clrr;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             uflow;

    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] exp_q [$];

    port_rx_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .cp(cp), .clr_(clr_), .fr(fr), .d(d), .rd(rd),
        .oeb_(oeb_), .clrr(clrr), .q(q), .empty(empty), .full(full),
        .count(count), .uflow(uflow)
    );

    always #5 cp = ~cp;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard monitor: every pop the DUT will accept is checked against the queue head.
    always @(negedge cp) begin
        if (clr_ && rd && !empty) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: q=%0h but no word expected", q);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (q !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", q, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        clr_ = 1'b0;
        rd   = 1'b0;
        @(posedge cp); #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full),  0);
        chk("rst_q",     32'(q),     0);
        chk("rst_oeb",   32'(oeb_),  1);
        chk("rst_clrr",  32'(clrr),  0);
        chk("rst_uflow", 32'(uflow), 0);
        @(posedge cp); #1;
        clr_ = 1'b1;
        exp_q.delete();
    endtask

    task automatic start_word(input logic [WIDTH-1:0] v);
        d  = v;
        fr = 1'b1;
    endtask

    // Port side: wait for the clear pulse, drop the flag, let the FSM return to IDLE.
    task automatic finish_word(input logic [WIDTH-1:0] v, output int n, output int lows);
        n    = 0;
        lows = 0;
        while (!clrr && n < 60) begin
            @(posedge cp); #1;
            n++;
            if (!oeb_) lows++;
        end
        if (!clrr) begin
            tests++;
            fails++;
            $display("FAIL clrr_timeout: no clear pulse for word %0h", v);
        end
        fr = 1'b0;
        exp_q.push_back(v);
        @(posedge cp); #1;
        chk("clrr_one_cycle", 32'(clrr), 0);
        repeat (2) @(posedge cp);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] v);
        int n, lows;
        start_word(v);
        finish_word(v, n, lows);
    endtask

    task automatic pop_n(input int n);
        rd = 1'b1;
        repeat (n) @(posedge cp);
        #1;
        rd = 1'b0;
    endtask

    // Capture a word while popping on the CAPTURE->CLEAR edge.
    task automatic capture_with_pop(input logic [WIDTH-1:0] v);
        int n, lows, k;
        start_word(v);
        k = 0;
        while (oeb_ && k < 20) begin
            @(posedge cp); #1;
            k++;
        end
        chk("enable_seen", 32'(oeb_), 0);
        @(posedge cp); #1;
        rd = 1'b1;
        @(posedge cp); #1;
        rd = 1'b0;
        chk("clear_after_pop_edge", 32'(clrr), 1);
        finish_word(v, n, lows);
    endtask

    initial begin
        int n, lows, k;
        clr_ = 1'b0;
        fr   = 1'b0;
        rd   = 1'b0;
        d    = '0;

        // Single word with latency and strobe widths.
        do_reset();
        start_word(8'hA5);
        finish_word(8'hA5, n, lows);
        chk("latency_edges", 32'(n), 5);
        chk("oeb_low_cycles", 32'(lows), 2);
        chk("single_count", 32'(count), 1);
        chk("single_q", 32'(q), 32'h A5);
        chk("single_empty", 32'(empty), 0);
        pop_n(1);
        chk("single_drained_empty", 32'(empty), 1);
        chk("single_drained_q", 32'(q), 0);

        // Fill and backpressure.
        do_reset();
        for (int i = 1; i <= 4; i++) send_word(8'(i));
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        start_word(8'h05);
        repeat (10) @(posedge cp);
        #1;
        chk("bp_oeb", 32'(oeb_), 1);
        chk("bp_count", 32'(count), 4);
        pop_n(1);
        chk("bp_q_after_pop", 32'(q), 32'h02);
        finish_word(8'h05, n, lows);
        chk("bp_count_refill", 32'(count), 4);
        chk("bp_full_refill", 32'(full), 1);
        pop_n(4);
        chk("bp_all_popped", 32'(exp_q.size()), 0);
        chk("bp_empty", 32'(empty), 1);

        // Order and pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) send_word(8'h10 + 8'(i));
        pop_n(2);
        chk("wrap_count_mid", 32'(count), 2);
        send_word(8'h14);
        send_word(8'h15);
        chk("wrap_count_full", 32'(count), 4);
        pop_n(4);
        chk("wrap_all_popped", 32'(exp_q.size()), 0);
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_q_zero", 32'(q), 0);

        // Simultaneous push and pop at count=2.
        do_reset();
        send_word(8'h20);
        send_word(8'h21);
        capture_with_pop(8'h22);
        chk("simul_count", 32'(count), 2);
        chk("simul_head", 32'(q), 32'h21);
        pop_n(2);
        chk("simul_drained", 32'(exp_q.size()), 0);

        // Simultaneous push and pop at count=1: pushed word falls through.
        do_reset();
        send_word(8'h30);
        capture_with_pop(8'h31);
        chk("fwft_count", 32'(count), 1);
        chk("fwft_q", 32'(q), 32'h31);
        pop_n(1);
        chk("fwft_empty", 32'(empty), 1);

        // Underflow is ignored and sticky.
        do_reset();
        pop_n(2);
        chk("uflow_count", 32'(count), 0);
        chk("uflow_set", 32'(uflow), 1);
        chk("uflow_empty", 32'(empty), 1);
        repeat (5) @(posedge cp);
        #1;
        chk("uflow_sticky", 32'(uflow), 1);

        // Reset during CAPTURE with the flag held: word discarded then re-read.
        do_reset();
        start_word(8'h40);
        k = 0;
        while (oeb_ && k < 20) begin
            @(posedge cp); #1;
            k++;
        end
        chk("mid_enable_seen", 32'(oeb_), 0);
        @(posedge cp); #1;
        chk("mid_capture_oeb", 32'(oeb_), 0);
        clr_ = 1'b0;
        @(posedge cp); #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_oeb", 32'(oeb_), 1);
        chk("mid_rst_clrr", 32'(clrr), 0);
        clr_ = 1'b1;
        finish_word(8'h40, n, lows);
        chk("mid_recapture_count", 32'(count), 1);
        chk("mid_recapture_q", 32'(q), 32'h40);
        pop_n(1);
        chk("mid_drained", 32'(exp_q.size()), 0);

        repeat (2) @(posedge cp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
